mem_bus_arbiter: RTL

//  Merges the core's instruction (imem_*) and data (dmem_*) ports onto one shared memory port for single-RAM

---
 rtl/mem_bus_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port to one-port memory arbiter: grants the instruction or data channel onto a
// registered shared memory request and steers the completion back to the owning port.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DATA_PRIORITY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // instruction channel
   input  logic                    imem_valid_i,
   output logic                    imem_ready_o,
   input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
   input  logic [DATA_WIDTH-1:0]   imem_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] imem_we_i,
   output logic [DATA_WIDTH-1:0]   imem_rdata_o,
   // data channel
   input  logic                    dmem_valid_i,
   output logic                    dmem_ready_o,
   input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
   input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] dmem_we_i,
   output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
   // shared memory port
   output logic                    mem_valid_o,
   input  logic                    mem_ready_i,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_we_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_rr_dmem;   // data port wins the next round-robin tie
   logic                  r_mem_valid;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [BE_WIDTH-1:0]   r_mem_we;

   logic                  w_grant_i;
   logic                  w_grant_d;
   logic                  w_done;
   logic                  w_dmem_wins;

   assign w_dmem_wins = dmem_valid_i &
                        (~imem_valid_i | (DATA_PRIORITY != 0) | r_rr_dmem);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dmem_wins) begin
               w_grant_d   = 1'b1;
               w_state_nxt = BUSY_D;
            end else if (imem_valid_i) begin
               w_grant_i   = 1'b1;
               w_state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready_i) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr_dmem   <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_d) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= dmem_addr_i;
            r_mem_wdata <= dmem_wdata_i;
            r_mem_we    <= dmem_we_i;
         end else if (w_grant_i) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= imem_addr_i;
            r_mem_wdata <= imem_wdata_i;
            r_mem_we    <= imem_we_i;
         end else if (w_done) begin
            r_mem_valid <= 1'b0;
            r_rr_dmem   <= (r_state == BUSY_I);
         end
      end
   end

   // Gated by rst_n so a completion arriving while reset is held never leaks out.
   assign imem_ready_o = rst_n & (r_state == BUSY_I) & mem_ready_i;
   assign dmem_ready_o = rst_n & (r_state == BUSY_D) & mem_ready_i;
   assign imem_rdata_o = mem_rdata_i;
   assign dmem_rdata_o = mem_rdata_i;

   assign mem_valid_o = r_mem_valid;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_we_o    = r_mem_we;

endmodule
